// File: rtl/mips_muldiv_unit_if.sv
// Pipeline-side bundle for the MIPS multiply/divide unit: launch, MTHI/MTLO, HI/LO and status.
interface mips_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             abort;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             stall;

  modport master (
    output start, op, src_a, src_b, abort, wr_hi, wr_lo, wdata, rd_hilo,
    input  hi, lo, busy, done, div_zero, stall
  );

  modport slave (
    input  start, op, src_a, src_b, abort, wr_hi, wr_lo, wdata, rd_hilo,
    output hi, lo, busy, done, div_zero, stall
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and hazard stall request.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier, divide timing unchanged.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_muldiv_unit_if.slave    bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic             divZero;
  logic [WIDTH-1:0] opM;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             busyReg;
  logic             doneReg;
  logic             divZeroReg;

  logic               acceptStart;
  logic               startSigned;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH+1:0]   divTrial;
  logic               divFits;
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodRes;
  logic [WIDTH-1:0]   quotRes;
  logic [WIDTH-1:0]   remRes;

  // Operand conditioning, one datapath step, and sign fix-up of the final result
  always_comb begin
    acceptStart = bus.start & ((state == IDLE) | (state == DONE));
    startSigned = ~bus.op[0];
    magA        = (startSigned & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    magB        = (startSigned & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    mulSum      = {1'b0, accHi} + (accLo[0] ? {1'b0, opM} : {(WIDTH+1){1'b0}});
    divTrial    = {1'b0, accHi, accLo[WIDTH-1]} - {2'b00, opM};
    divFits     = (divTrial[WIDTH+1:WIDTH] == 2'b00);
    prodRaw     = {accHi, accLo};
    prodRes     = negRes ? -prodRaw : prodRaw;
    // A zero divisor yields an all-ones quotient regardless of operand signs
    quotRes     = (negRes & ~divZero) ? -accLo : accLo;
    remRes      = negRem ? -accHi : accHi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      isDiv      <= 1'b0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      divZero    <= 1'b0;
      opM        <= '0;
      accHi      <= '0;
      accLo      <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (acceptStart) begin
            state   <= CALC;
            busyReg <= 1'b1;
            isDiv   <= bus.op[1];
            negRes  <= startSigned & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            negRem  <= startSigned & bus.src_a[WIDTH-1];
            divZero <= bus.op[1] & (bus.src_b == '0);
            accHi   <= '0;
            // Multiply: multiplier shifts out of accLo. Divide: dividend shifts out of accLo.
            opM     <= bus.op[1] ? magB : magA;
            accLo   <= bus.op[1] ? magA : magB;
`ifdef MULDIV_FAST_MUL_EN
            cnt     <= bus.op[1] ? CNT_W'(WIDTH - 1) : '0;
`else
            cnt     <= CNT_W'(WIDTH - 1);
`endif
          end else begin
            if (bus.wr_hi) hiReg <= bus.wdata;
            if (bus.wr_lo) loReg <= bus.wdata;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state   <= IDLE;
            busyReg <= 1'b0;
          end else begin
            if (isDiv) begin
              if (divFits) begin
                accHi <= divTrial[WIDTH-1:0];
                accLo <= {accLo[WIDTH-2:0], 1'b1};
              end else begin
                accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
                accLo <= {accLo[WIDTH-2:0], 1'b0};
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              {accHi, accLo} <= (2*WIDTH)'(opM) * (2*WIDTH)'(accLo);
`else
              {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
`endif
            end
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          state   <= bus.abort ? IDLE : DONE;
          busyReg <= 1'b0;
          if (!bus.abort) begin
            doneReg <= 1'b1;
            if (isDiv) begin
              hiReg      <= remRes;
              loReg      <= quotRes;
              divZeroReg <= divZero;
            end else begin
              {hiReg, loReg} <= prodRes;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.stall    = busyReg & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);
endmodule
